traffic_ctrl_rr: RTL and testbench



---
 rtl/traffic_ctrl_rr.sv | 246 ++++++++++++++++++++++++
 tb/tb_traffic_ctrl_rr.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_rr.sv
// -----------------------------------------------------------------------------
// traffic_ctrl_rr
// N-way intersection controller. Request-driven round-robin arbitration with
// minimum/maximum green (a way's own request extends its green up to the
// maximum), followed by an amber phase and an optional all-red clearance phase.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   req          level request per way
//   green        one-hot green lamp (or all zero)
//   amber        one-hot amber lamp (or all zero)
//   red          red lamps, always ~(green | amber)
//   active_way   way that currently owns the phase
//   phase        0 = GREEN, 1 = AMBER, 2 = ALL_RED
//   phase_cnt    cycles spent in the current phase, 0 on its first cycle
//
// Optional build macro TRAFFIC_PREEMPT_EN adds:
//   preempt      emergency preemption request
//   preempt_way  way that preemption wants green on
//
// All outputs come straight from flops. Lamp values are computed from the
// next-state decision and registered alongside it, so there is no
// combinational path from req to any lamp.
// -----------------------------------------------------------------------------
module traffic_ctrl_rr #(
    parameter int NUM_WAYS     = 4,
    parameter int CNT_W        = 8,
    parameter int GREEN_MIN    = 2,
    parameter int GREEN_MAX    = 16,
    parameter int AMBER_TIME   = 3,
    parameter int ALL_RED_TIME = 1,
    localparam int AW          = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_WAYS-1:0] req,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                preempt,
    input  logic [AW-1:0]       preempt_way,
`endif
    output logic [NUM_WAYS-1:0] green,
    output logic [NUM_WAYS-1:0] amber,
    output logic [NUM_WAYS-1:0] red,
    output logic [AW-1:0]       active_way,
    output logic [1:0]          phase,
    output logic [CNT_W-1:0]    phase_cnt
);

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_AMBER   = 2'd1,
        PH_ALL_RED = 2'd2
    } phase_e;

    localparam logic [CNT_W-1:0]    CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    GMIN_LAST    = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0]    GMAX_LAST    = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0]    AMBER_LAST   = CNT_W'(AMBER_TIME - 1);
    localparam logic [CNT_W-1:0]    ALL_RED_LAST = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [NUM_WAYS-1:0] WAYS_ZERO    = {NUM_WAYS{1'b0}};
    localparam logic [NUM_WAYS-1:0] WAY0_ONEHOT  = {{(NUM_WAYS-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]       WAY_ZERO     = {AW{1'b0}};

    // Parameter sanity: any violation stops elaboration.
    generate
        if (NUM_WAYS < 2) begin : g_chk_ways
            $error("traffic_ctrl_rr: NUM_WAYS must be >= 2");
        end
        if (CNT_W < 1 || CNT_W > 30) begin : g_chk_cntw
            $error("traffic_ctrl_rr: CNT_W must be in 1..30");
        end
        if (GREEN_MIN < 1) begin : g_chk_gmin
            $error("traffic_ctrl_rr: GREEN_MIN must be >= 1");
        end
        if (GREEN_MAX < GREEN_MIN || GREEN_MAX > (1 << CNT_W) - 1) begin : g_chk_gmax
            $error("traffic_ctrl_rr: GREEN_MAX must be in GREEN_MIN..2^CNT_W-1");
        end
        if (AMBER_TIME < 1 || AMBER_TIME > (1 << CNT_W)) begin : g_chk_amber
            $error("traffic_ctrl_rr: AMBER_TIME must be in 1..2^CNT_W");
        end
        if (ALL_RED_TIME < 0 || ALL_RED_TIME > (1 << CNT_W)) begin : g_chk_allred
            $error("traffic_ctrl_rr: ALL_RED_TIME must be in 0..2^CNT_W");
        end
    endgenerate

    // One-hot decode of a way index.
    function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [AW-1:0] w);
        logic [NUM_WAYS-1:0] v;
        v    = {NUM_WAYS{1'b0}};
        v[w] = 1'b1;
        return v;
    endfunction

    phase_e              phase_r;
    logic [AW-1:0]       active_way_r;
    logic [AW-1:0]       next_way_r;
    logic [CNT_W-1:0]    phase_cnt_r;
    logic [NUM_WAYS-1:0] green_r;
    logic [NUM_WAYS-1:0] amber_r;
    logic [NUM_WAYS-1:0] red_r;

    logic [NUM_WAYS-1:0] other_req_s;
    logic                rr_found_s;
    logic [AW-1:0]       rr_way_s;
    logic [AW-1:0]       rr_idx_s;
    logic                rr_exit_s;
    logic                green_exit_s;
    logic [AW-1:0]       grant_s;
`ifdef TRAFFIC_PREEMPT_EN
    logic                pre_valid_s;
    logic                pre_go_s;
    logic                pre_hold_s;
`endif

    phase_e              phase_nxt_s;
    logic [AW-1:0]       active_nxt_s;
    logic [AW-1:0]       next_way_nxt_s;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [NUM_WAYS-1:0] green_nxt_s;
    logic [NUM_WAYS-1:0] amber_nxt_s;

    // Round-robin search: first requesting way after active_way, wrapping.
    always_comb begin
        other_req_s = req & ~way_onehot(active_way_r);
        rr_found_s  = 1'b0;
        rr_way_s    = active_way_r;
        rr_idx_s    = active_way_r;
        for (int i = 1; i < NUM_WAYS; i++) begin
            rr_idx_s = AW'((int'(active_way_r) + i) % NUM_WAYS);
            if (!rr_found_s && other_req_s[rr_idx_s]) begin
                rr_found_s = 1'b1;
                rr_way_s   = rr_idx_s;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // GREEN exit decision and the way it grants; preemption overrides both.
    always_comb begin
        rr_exit_s = (phase_cnt_r >= GMIN_LAST) && (other_req_s != WAYS_ZERO) &&
                    (!req[active_way_r] || (phase_cnt_r >= GMAX_LAST));
`ifdef TRAFFIC_PREEMPT_EN
        // An index beyond NUM_WAYS-1 names no approach and is ignored.
        pre_valid_s  = preempt && (int'(preempt_way) < NUM_WAYS);
        pre_go_s     = pre_valid_s && (preempt_way != active_way_r);
        pre_hold_s   = pre_valid_s && (preempt_way == active_way_r);
        green_exit_s = pre_go_s || (rr_exit_s && !pre_hold_s);
        grant_s      = pre_go_s ? preempt_way : rr_way_s;
`else
        green_exit_s = rr_exit_s;
        grant_s      = rr_way_s;
`endif
    end

    // Phase sequencing, saturating phase counter and lamp decode of next state.
    always_comb begin
        phase_nxt_s    = phase_r;
        active_nxt_s   = active_way_r;
        next_way_nxt_s = next_way_r;
        cnt_inc_s      = (phase_cnt_r == CNT_MAX) ? CNT_MAX : (phase_cnt_r + CNT_ONE);
        cnt_nxt_s      = cnt_inc_s;
        case (phase_r)
            PH_GREEN: begin
                if (green_exit_s) begin
                    phase_nxt_s    = PH_AMBER;
                    next_way_nxt_s = grant_s;
                    cnt_nxt_s      = CNT_ZERO;
                end else begin
                    phase_nxt_s    = PH_GREEN;
                end
            end
            PH_AMBER: begin
                if (phase_cnt_r == AMBER_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (ALL_RED_TIME == 0) begin
                        phase_nxt_s  = PH_GREEN;
                        active_nxt_s = next_way_r;
                    end else begin
                        phase_nxt_s  = PH_ALL_RED;
                    end
                end else begin
                    phase_nxt_s = PH_AMBER;
                end
            end
            PH_ALL_RED: begin
                if (phase_cnt_r == ALL_RED_LAST) begin
                    phase_nxt_s  = PH_GREEN;
                    active_nxt_s = next_way_r;
                    cnt_nxt_s    = CNT_ZERO;
                end else begin
                    phase_nxt_s  = PH_ALL_RED;
                end
            end
            default: begin
                // Unreachable encoding: fall back to clearance before any green.
                phase_nxt_s = PH_ALL_RED;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase

        if (phase_nxt_s == PH_GREEN) begin
            green_nxt_s = way_onehot(active_nxt_s);
            amber_nxt_s = WAYS_ZERO;
        end else if (phase_nxt_s == PH_AMBER) begin
            green_nxt_s = WAYS_ZERO;
            amber_nxt_s = way_onehot(active_nxt_s);
        end else begin
            green_nxt_s = WAYS_ZERO;
            amber_nxt_s = WAYS_ZERO;
        end
    end

    // State and lamp registers; reset forces an immediate green on way 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r      <= PH_GREEN;
            active_way_r <= WAY_ZERO;
            next_way_r   <= WAY_ZERO;
            phase_cnt_r  <= CNT_ZERO;
            green_r      <= WAY0_ONEHOT;
            amber_r      <= WAYS_ZERO;
            red_r        <= ~WAY0_ONEHOT;
        end else begin
            phase_r      <= phase_nxt_s;
            active_way_r <= active_nxt_s;
            next_way_r   <= next_way_nxt_s;
            phase_cnt_r  <= cnt_nxt_s;
            green_r      <= green_nxt_s;
            amber_r      <= amber_nxt_s;
            red_r        <= ~(green_nxt_s | amber_nxt_s);
        end
    end

    assign green      = green_r;
    assign amber      = amber_r;
    assign red        = red_r;
    assign active_way = active_way_r;
    assign phase      = phase_r;
    assign phase_cnt  = phase_cnt_r;

endmodule

// File: tb/tb_traffic_ctrl_rr.sv
`timescale 1ns/1ps
module tb_traffic_ctrl_rr;

    localparam int NW   = 4;
    localparam int CW   = 8;
    localparam int GMIN = 2;
    localparam int GMAX = 16;
    localparam int AT   = 3;
    localparam int ART  = 1;
    localparam int AW   = 2;
    localparam int BW   = 3*NW + AW + 2 + CW;

    typedef logic [BW-1:0] bundle_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NW-1:0] req   = 4'b0000;
    logic [NW-1:0] req_s = 4'b0000;

    logic [NW-1:0] green, amber, red;
    logic [AW-1:0] active_way;
    logic [1:0]    phase;
    logic [CW-1:0] phase_cnt;

    logic [NW-1:0] green_s, amber_s, red_s;
    logic [AW-1:0] active_way_s;
    logic [1:0]    phase_s;
    logic [3:0]    phase_cnt_s;

`ifdef TRAFFIC_PREEMPT_EN
    logic          preempt     = 1'b0;
    logic [AW-1:0] preempt_way = 2'd0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    bundle_t exp_q[$];
    bundle_t exp_b;

    // model state
    int m_phase  = 0;
    int m_active = 0;
    int m_next   = 0;
    int m_cnt    = 0;

    always #5 clk = ~clk;

    traffic_ctrl_rr #(
        .NUM_WAYS(NW), .CNT_W(CW), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .AMBER_TIME(AT), .ALL_RED_TIME(ART)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
`ifdef TRAFFIC_PREEMPT_EN
        .preempt(preempt), .preempt_way(preempt_way),
`endif
        .green(green), .amber(amber), .red(red),
        .active_way(active_way), .phase(phase), .phase_cnt(phase_cnt)
    );

    // Narrow-counter instance for the saturation scenario.
    traffic_ctrl_rr #(
        .NUM_WAYS(NW), .CNT_W(4), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX - 1),
        .AMBER_TIME(AT), .ALL_RED_TIME(ART)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .req(req_s),
`ifdef TRAFFIC_PREEMPT_EN
        .preempt(1'b0), .preempt_way(2'd0),
`endif
        .green(green_s), .amber(amber_s), .red(red_s),
        .active_way(active_way_s), .phase(phase_s), .phase_cnt(phase_cnt_s)
    );

    // Reference behaviour of one clock edge, taken from the intended sequencing.
    task automatic model_step();
        logic [NW-1:0] oth;
        logic          leave;
        int            gw;
        int            cmax;
        cmax = (1 << CW) - 1;
        if (!rst_n) begin
            m_phase = 0; m_active = 0; m_next = 0; m_cnt = 0;
            return;
        end
        case (m_phase)
            0: begin
                oth = req;
                oth[m_active] = 1'b0;
                leave = (m_cnt >= GMIN - 1) && (oth != 4'b0000) &&
                        (!req[m_active] || (m_cnt >= GMAX - 1));
                gw = m_active;
                // scan from farthest to nearest so the nearest requester wins
                for (int k = NW - 1; k >= 1; k--) begin
                    if (oth[(m_active + k) % NW]) gw = (m_active + k) % NW;
                end
`ifdef TRAFFIC_PREEMPT_EN
                if (preempt && int'(preempt_way) != m_active) begin
                    leave = 1'b1;
                    gw    = int'(preempt_way);
                end else if (preempt) begin
                    leave = 1'b0;
                end
`endif
                if (leave) begin
                    m_next = gw; m_phase = 1; m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt < cmax) ? m_cnt + 1 : m_cnt;
                end
            end
            1: begin
                if (m_cnt == AT - 1) begin
                    m_cnt = 0;
                    if (ART == 0) begin m_phase = 0; m_active = m_next; end
                    else m_phase = 2;
                end else m_cnt = m_cnt + 1;
            end
            default: begin
                if (m_cnt == ART - 1) begin
                    m_phase = 0; m_active = m_next; m_cnt = 0;
                end else m_cnt = m_cnt + 1;
            end
        endcase
    endtask

    function automatic bundle_t model_bundle();
        logic [NW-1:0] g;
        logic [NW-1:0] a;
        g = 4'b0000;
        a = 4'b0000;
        if (m_phase == 0) g[m_active] = 1'b1;
        else if (m_phase == 1) a[m_active] = 1'b1;
        return {g, a, ~(g | a), AW'(m_active), 2'(m_phase), CW'(m_cnt)};
    endfunction

    // One clock: predict, queue the prediction, let the edge happen.
    task automatic tick();
        model_step();
        exp_q.push_back(model_bundle());
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each queued prediction against the outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            n_cmp++;
            if ({green, amber, red, active_way, phase, phase_cnt} !== exp_b) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got=%h expected=%h", $time,
                         {green, amber, red, active_way, phase, phase_cnt}, exp_b);
            end
        end
    end

    // Tick until a GREEN phase begins (bounded).
    task automatic wait_green_entry(output bit ok);
        logic [1:0] prev;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            prev = phase;
            tick();
            if (phase == 2'd0 && prev != 2'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Count green cycles starting from the current (cnt 0) green cycle.
    task automatic measure_green(output int len);
        len = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (phase == 2'd0) len++;
            else break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (3) tick();
        n_cmp++;
        if ({green, amber, red, active_way, phase, phase_cnt} !==
            {4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state got=%h required=%h",
                     {green, amber, red, active_way, phase, phase_cnt},
                     {4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0, 8'd0});
        end
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();
        // glitch between edges must be ignored
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (phase_cnt !== 8'd2 || green !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_glitch cnt=%0d green=%b required cnt=2 green=0001",
                     phase_cnt, green);
        end
    endtask

    task automatic test_basic_cycle();
        rst_n = 1'b0;
        req   = 4'b0100;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (phase !== 2'd1 || amber !== 4'b0001 || green !== 4'b0000) begin
            n_fail++;
            $display("FAIL basic_amber phase=%0d amber=%b green=%b required 1/0001/0000",
                     phase, amber, green);
        end
        repeat (3) tick();
        n_cmp++;
        if (phase !== 2'd2 || red !== 4'b1111) begin
            n_fail++;
            $display("FAIL basic_allred phase=%0d red=%b required 2/1111", phase, red);
        end
        tick();
        n_cmp++;
        if (green !== 4'b0100 || active_way !== 2'd2 || phase_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL basic_green2 green=%b way=%0d cnt=%0d required 0100/2/0",
                     green, active_way, phase_cnt);
        end
    endtask

    task automatic test_round_robin();
        int exp_way[4] = '{3, 0, 1, 3};
        bit ok;
        int len;
        req = 4'b1011;
        for (int g = 0; g < 4; g++) begin
            wait_green_entry(ok);
            n_cmp++;
            if (!ok || int'(active_way) != exp_way[g]) begin
                n_fail++;
                $display("FAIL rr_grant%0d way=%0d entered=%0d required way=%0d",
                         g, active_way, ok, exp_way[g]);
            end
            measure_green(len);
            n_cmp++;
            if (len != GMAX) begin
                n_fail++;
                $display("FAIL rr_length%0d got=%0d required=%0d", g, len, GMAX);
            end
        end
    endtask

    task automatic test_extension();
        bit ok;
        int len;
        req = 4'b0011;
        wait_green_entry(ok);
        measure_green(len);
        n_cmp++;
        if (len != GMAX || amber !== 4'b0001) begin
            n_fail++;
            $display("FAIL ext_full len=%0d amber=%b required %0d/0001", len, amber, GMAX);
        end
        wait_green_entry(ok);
        wait_green_entry(ok);
        n_cmp++;
        if (!ok || active_way !== 2'd0) begin
            n_fail++;
            $display("FAIL ext_regrant way=%0d entered=%0d required way=0", active_way, ok);
        end
        for (int i = 0; i < 10; i++) begin
            if (phase_cnt == 8'd5) break;
            tick();
        end
        req = 4'b0010;
        tick();
        n_cmp++;
        if (phase !== 2'd1 || amber !== 4'b0001) begin
            n_fail++;
            $display("FAIL ext_drop phase=%0d amber=%b required 1/0001", phase, amber);
        end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        req   = 4'b0000;
        req_s = 4'b0000;
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        n_cmp++;
        if (phase_cnt_s !== 4'd15 || green_s !== 4'b0001 || phase_s !== 2'd0) begin
            n_fail++;
            $display("FAIL sat_hold cnt=%0d green=%b phase=%0d required 15/0001/0",
                     phase_cnt_s, green_s, phase_s);
        end
        req_s = 4'b1000;
        tick();
        n_cmp++;
        if (phase_s !== 2'd1 || amber_s !== 4'b0001 || phase_cnt_s !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_exit phase=%0d amber=%b cnt=%0d required 1/0001/0",
                     phase_s, amber_s, phase_cnt_s);
        end
        req_s = 4'b0000;
    endtask

    task automatic test_reset_mid_amber();
        rst_n = 1'b0;
        req   = 4'b0100;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (phase == 2'd1) break;
            tick();
        end
        tick();
        n_cmp++;
        if (phase !== 2'd1 || phase_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL mid_amber_setup phase=%0d cnt=%0d required 1/1", phase, phase_cnt);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({green, amber, phase, phase_cnt} !== {4'b0001, 4'b0000, 2'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL mid_amber_reset got=%h required=%h",
                     {green, amber, phase, phase_cnt}, {4'b0001, 4'b0000, 2'd0, 8'd0});
        end
        rst_n = 1'b1;
    endtask

`ifdef TRAFFIC_PREEMPT_EN
    task automatic test_preempt();
        bit ok;
        rst_n = 1'b0;
        req   = 4'b0010;
        tick();
        rst_n = 1'b1;
        wait_green_entry(ok);
        n_cmp++;
        if (!ok || active_way !== 2'd1 || phase_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL pre_setup way=%0d cnt=%0d required 1/0", active_way, phase_cnt);
        end
        preempt     = 1'b1;
        preempt_way = 2'd3;
        tick();
        n_cmp++;
        if (phase !== 2'd1 || amber !== 4'b0010) begin
            n_fail++;
            $display("FAIL pre_amber phase=%0d amber=%b required 1/0010", phase, amber);
        end
        repeat (4) tick();
        n_cmp++;
        if (green !== 4'b1000 || active_way !== 2'd3) begin
            n_fail++;
            $display("FAIL pre_green green=%b way=%0d required 1000/3", green, active_way);
        end
        req = 4'b0011;
        repeat (20) tick();
        n_cmp++;
        if (phase !== 2'd0 || active_way !== 2'd3 || phase_cnt !== 8'd20) begin
            n_fail++;
            $display("FAIL pre_hold phase=%0d way=%0d cnt=%0d required 0/3/20",
                     phase, active_way, phase_cnt);
        end
        preempt = 1'b0;
        tick();
        n_cmp++;
        if (phase !== 2'd1 || amber !== 4'b1000) begin
            n_fail++;
            $display("FAIL pre_release phase=%0d amber=%b required 1/1000", phase, amber);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_cycle();
        test_round_robin();
        test_extension();
        test_saturation();
        test_reset_mid_amber();
`ifdef TRAFFIC_PREEMPT_EN
        test_preempt();
`endif
        #10;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
